bp_resolve_queue: RTL and testbench
===================================

BP_RESOLVE_QUEUE -- requirements
Module: bp_resolve_queue

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port rdy, input, 1 bit: global ready; when low, the block stalls.
REQ-004 SHALL have port in_fetch_valid, input, 1 bit: fetcher requests allocation of a branch entry.
REQ-005 SHALL have port in_fetch_tag, input, 8 bits: predictor table index of the fetched branch.
REQ-006 SHALL have port in_fetch_pred, input, 1 bit: prediction given to the fetcher (1 = taken).
REQ-007 SHALL have port out_fetch_idx, output, 3 bits: queue index the fetched branch receives; combinational, equals tail.
REQ-008 SHALL have port out_full, output, 1 bit: combinational, 1 when count == 8.
REQ-009 SHALL have port in_ex_valid, input, 1 bit: execution unit reports a branch outcome.
REQ-010 SHALL have port in_ex_idx, input, 3 bits: queue index of the resolved branch.
REQ-011 SHALL have port in_ex_taken, input, 1 bit: actual branch outcome.
REQ-012 SHALL have port in_commit, input, 1 bit: ROB requests in-order retirement of the head branch.
REQ-013 SHALL have port out_bp_valid, output, 1 bit, registered: predictor update strobe.
REQ-014 SHALL have port out_bp_tag, output, 8 bits, registered: predictor entry to train.
REQ-015 SHALL have port out_bp_taken, output, 1 bit, registered: actual outcome used for training.
REQ-016 SHALL have port out_mispredict, output, 1 bit, registered: 1 when the retired branch's prediction differed from its outcome.

Function
REQ-017 SHALL implement an 8-entry circular FIFO; each entry holds valid, tag[7:0], pred, resolved, taken; head/tail are 3 bits and wrap 7->0; count is 4 bits (0..8).
REQ-018 Enqueue: on in_fetch_valid && !out_full, SHALL write {valid=1, tag, pred, resolved=0} at tail and advance tail by 1. in_fetch_valid while full SHALL be ignored with no state change.
REQ-019 Resolve: on in_ex_valid, SHALL set resolved=1 and taken=in_ex_taken at in_ex_idx only if that entry is valid. A resolve to an invalid entry SHALL be ignored. A repeat resolve SHALL overwrite taken.
REQ-020 Commit: on in_commit SHALL retire the head only if, at the clock edge, the head is valid and resolved; the head is then invalidated and advanced by 1.
REQ-020a On a retire, out_bp_valid, out_bp_tag and out_bp_taken SHALL be set next cycle, and out_mispredict = pred XOR taken.
REQ-021 A commit to an empty or unresolved head SHALL be ignored; out_bp_valid = 0 next cycle.
REQ-022 out_bp_valid and out_mispredict SHALL be one-cycle pulses; they are 0 on any cycle with no retire. out_bp_tag and out_bp_taken hold their last value.
REQ-023 Mispredict flush: on a retire with pred != taken, SHALL clear all valid bits and set head = tail = count = 0 on the same edge. An enqueue or resolve in that cycle SHALL be discarded.
REQ-024 Simultaneous enqueue and retire without mispredict: both SHALL take effect and count is unchanged. Enqueue is permitted when full only if a retire occurs in the same cycle? No: out_full gates enqueue regardless of a same-cycle retire.
REQ-025 Resolve and commit to the head in the same cycle: commit SHALL see the pre-edge resolved=0 and be ignored. The resolve SHALL take effect.
REQ-026 rdy = 0: no queue state SHALL change; out_bp_valid and out_mispredict SHALL be 0 on that edge.
REQ-027 Latency: allocate-to-resolvable 1 cycle; commit request to out_bp_valid 1 cycle.

Reset
REQ-028 On rst = 1 at a clock edge, all entries SHALL be invalid and head, tail and count 0; all registered outputs SHALL be 0. out_full = 0 and out_fetch_idx = 0 after reset. rst SHALL override rdy and every other input.

Verification
REQ-029 Stimulus: after reset, enqueue tag 0x12 pred 1, resolve idx 0 taken 1, then commit. Required: out_fetch_idx = 0 at allocation; one cycle after commit, out_bp_valid = 1, out_bp_tag = 0x12, out_bp_taken = 1, out_mispredict = 0.
REQ-030 Stimulus: 8 enqueues then a 9th. Required: out_full = 1 after the 8th; the 9th is dropped. Retire one, enqueue one: tail wraps to index 0 with count 8.
REQ-031 Stimulus: enqueue 3 branches; resolve idx 0 as not-taken against pred 1; commit. Required: out_mispredict = 1, out_bp_taken = 0; next cycle count = 0, out_fetch_idx = 0, and resolves to idx 1 and 2 are ignored.
REQ-032 Stimulus: commit with head unresolved; also resolve and commit the head in the same cycle. Required: out_bp_valid = 0 both times; a commit on the following cycle retires.
REQ-033 Stimulus: hold rdy = 0 while driving enqueue, resolve and commit; then assert rst mid-queue. Required: no state change while rdy = 0; after rst, all outputs = 0 and count = 0.

Source files
------------

// File: rtl/bp_resolve_queue.sv
// Branch resolve queue: 8-entry in-order tracker of fetched branches that trains the predictor when a resolved head retires.
// Enqueue, resolve and retire each take one edge; a mispredicting retire flushes the whole queue on that same edge.
module bp_resolve_queue (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       in_fetch_valid,
  input  logic [7:0] in_fetch_tag,
  input  logic       in_fetch_pred,
  output logic [2:0] out_fetch_idx,
  output logic       out_full,
  input  logic       in_ex_valid,
  input  logic [2:0] in_ex_idx,
  input  logic       in_ex_taken,
  input  logic       in_commit,
  output logic       out_bp_valid,
  output logic [7:0] out_bp_tag,
  output logic       out_bp_taken,
  output logic       out_mispredict
);

  logic [7:0]      valid_q, valid_d, pred_q, pred_d;
  logic [7:0]      res_q, res_d, taken_q, taken_d;
  logic [7:0][7:0] tag_q, tag_d;
  logic [2:0]      head_q, head_d, tail_q, tail_d;
  logic [3:0]      count_q, count_d;
  logic            bp_valid_q, bp_valid_d, bp_taken_q, bp_taken_d;
  logic            mispredict_q, mispredict_d;
  logic [7:0]      bp_tag_q, bp_tag_d;
  logic            enq, retire, flush;

  assign out_full       = (count_q == 4'd8);
  assign out_fetch_idx  = tail_q;
  assign out_bp_valid   = bp_valid_q;
  assign out_bp_tag     = bp_tag_q;
  assign out_bp_taken   = bp_taken_q;
  assign out_mispredict = mispredict_q;

  always_comb begin
    valid_d      = valid_q;
    pred_d       = pred_q;
    res_d        = res_q;
    taken_d      = taken_q;
    tag_d        = tag_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    bp_valid_d   = 1'b0;
    mispredict_d = 1'b0;
    bp_tag_d     = bp_tag_q;
    bp_taken_d   = bp_taken_q;
    enq          = 1'b0;
    retire       = 1'b0;
    flush        = 1'b0;
    if (rdy) begin
      enq    = in_fetch_valid && !out_full;
      // Retire looks only at pre-edge state, so a same-cycle resolve cannot enable it.
      retire = in_commit && valid_q[head_q] && res_q[head_q];
      flush  = retire && (pred_q[head_q] != taken_q[head_q]);
      if (retire) begin
        bp_valid_d   = 1'b1;
        bp_tag_d     = tag_q[head_q];
        bp_taken_d   = taken_q[head_q];
        mispredict_d = flush;
      end
      if (flush) begin
        valid_d = '0;
        head_d  = 3'd0;
        tail_d  = 3'd0;
        count_d = 4'd0;
      end else begin
        if (in_ex_valid && valid_q[in_ex_idx]) begin
          res_d[in_ex_idx]   = 1'b1;
          taken_d[in_ex_idx] = in_ex_taken;
        end
        if (enq) begin
          valid_d[tail_q] = 1'b1;
          tag_d[tail_q]   = in_fetch_tag;
          pred_d[tail_q]  = in_fetch_pred;
          res_d[tail_q]   = 1'b0;
          tail_d          = tail_q + 3'd1;
        end
        if (retire) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + 3'd1;
        end
        count_d = count_q + {3'b000, enq} - {3'b000, retire};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      pred_q       <= '0;
      res_q        <= '0;
      taken_q      <= '0;
      tag_q        <= '0;
      head_q       <= 3'd0;
      tail_q       <= 3'd0;
      count_q      <= 4'd0;
      bp_valid_q   <= 1'b0;
      bp_tag_q     <= 8'd0;
      bp_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pred_q       <= pred_d;
      res_q        <= res_d;
      taken_q      <= taken_d;
      tag_q        <= tag_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      bp_valid_q   <= bp_valid_d;
      bp_tag_q     <= bp_tag_d;
      bp_taken_q   <= bp_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue; expected retirements are queued when commits are driven and checked on the following cycle.
module tb_bp_resolve_queue;

  logic       clk = 1'b0;
  logic       rst, rdy;
  logic       in_fetch_valid, in_fetch_pred;
  logic [7:0] in_fetch_tag;
  logic [2:0] out_fetch_idx;
  logic       out_full;
  logic       in_ex_valid, in_ex_taken, in_commit;
  logic [2:0] in_ex_idx;
  logic       out_bp_valid, out_bp_taken, out_mispredict;
  logic [7:0] out_bp_tag;

  typedef struct packed {
    logic [7:0] tag;
    logic       taken;
    logic       mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bp_resolve_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_fetch_valid(in_fetch_valid), .in_fetch_tag(in_fetch_tag), .in_fetch_pred(in_fetch_pred),
    .out_fetch_idx(out_fetch_idx), .out_full(out_full),
    .in_ex_valid(in_ex_valid), .in_ex_idx(in_ex_idx), .in_ex_taken(in_ex_taken),
    .in_commit(in_commit),
    .out_bp_valid(out_bp_valid), .out_bp_tag(out_bp_tag),
    .out_bp_taken(out_bp_taken), .out_mispredict(out_mispredict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: sample 1 time unit after the edge, score the predictor port, then idle the request inputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    chk("bp_valid", {31'd0, out_bp_valid}, {31'd0, sb.size() != 0});
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (out_bp_valid === 1'b1) begin
        chk("bp_tag", {24'd0, out_bp_tag}, {24'd0, e.tag});
        chk("bp_taken", {31'd0, out_bp_taken}, {31'd0, e.taken});
        chk("mispredict", {31'd0, out_mispredict}, {31'd0, e.mis});
      end
    end else begin
      chk("mispredict_idle", {31'd0, out_mispredict}, 32'd0);
    end
    in_fetch_valid = 1'b0;
    in_fetch_tag   = 8'd0;
    in_fetch_pred  = 1'b0;
    in_ex_valid    = 1'b0;
    in_ex_idx      = 3'd0;
    in_ex_taken    = 1'b0;
    in_commit      = 1'b0;
  endtask

  task automatic fetch(input logic [7:0] tag, input logic pred);
    in_fetch_valid = 1'b1;
    in_fetch_tag   = tag;
    in_fetch_pred  = pred;
  endtask

  task automatic resolve(input logic [2:0] idx, input logic taken);
    in_ex_valid = 1'b1;
    in_ex_idx   = idx;
    in_ex_taken = taken;
  endtask

  task automatic commit_exp(input logic [7:0] tag, input logic taken, input logic mis);
    in_commit = 1'b1;
    sb.push_back('{tag: tag, taken: taken, mis: mis});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1;
    in_fetch_valid = 1'b0; in_fetch_tag = 8'd0; in_fetch_pred = 1'b0;
    in_ex_valid = 1'b0; in_ex_idx = 3'd0; in_ex_taken = 1'b0; in_commit = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_full", {31'd0, out_full}, 32'd0);
    chk("rst_idx", {29'd0, out_fetch_idx}, 32'd0);
    chk("rst_tag", {24'd0, out_bp_tag}, 32'd0);
    chk("rst_taken", {31'd0, out_bp_taken}, 32'd0);

    // Basic allocate / resolve / retire.
    fetch(8'h12, 1'b1);
    chk("alloc_idx", {29'd0, out_fetch_idx}, 32'd0);
    tick();
    chk("idx_after_alloc", {29'd0, out_fetch_idx}, 32'd1);
    resolve(3'd0, 1'b1); tick();
    commit_exp(8'h12, 1'b1, 1'b0); tick();
    tick();
    chk("tag_holds", {24'd0, out_bp_tag}, 32'h12);

    // Commits that must be ignored: empty head, unresolved head, same-cycle resolve.
    in_commit = 1'b1; tick();
    fetch(8'h34, 1'b0); tick();
    in_commit = 1'b1; tick();
    resolve(3'd1, 1'b0); in_commit = 1'b1; tick();
    commit_exp(8'h34, 1'b0, 1'b0); tick();
    chk("idx_after_34", {29'd0, out_fetch_idx}, 32'd2);

    // Mispredict flush, with an enqueue and resolve discarded on the flush edge.
    fetch(8'h21, 1'b1); tick();
    fetch(8'h22, 1'b1); tick();
    fetch(8'h23, 1'b1); tick();
    resolve(3'd2, 1'b0); tick();
    repeat (2) begin
      resolve(3'd2, 1'b1); tick();
    end
    resolve(3'd2, 1'b0); tick();
    commit_exp(8'h21, 1'b0, 1'b1); fetch(8'h99, 1'b1); resolve(3'd3, 1'b1); tick();
    chk("flush_idx", {29'd0, out_fetch_idx}, 32'd0);
    chk("flush_full", {31'd0, out_full}, 32'd0);
    resolve(3'd1, 1'b1); tick();
    resolve(3'd2, 1'b1); tick();
    in_commit = 1'b1; tick();

    // Fill to 8, drop the 9th, then retire/enqueue around the full boundary.
    for (int i = 0; i < 8; i++) begin
      chk("fill_idx", {29'd0, out_fetch_idx}, i);
      chk("fill_notfull", {31'd0, out_full}, 32'd0);
      fetch(8'h40 + 8'(i), 1'b1); tick();
    end
    chk("full_after_8", {31'd0, out_full}, 32'd1);
    chk("wrap_idx", {29'd0, out_fetch_idx}, 32'd0);
    fetch(8'hFF, 1'b0); tick();
    chk("ninth_full", {31'd0, out_full}, 32'd1);
    chk("ninth_idx", {29'd0, out_fetch_idx}, 32'd0);
    resolve(3'd0, 1'b1); tick();
    commit_exp(8'h40, 1'b1, 1'b0); tick();
    chk("retire_notfull", {31'd0, out_full}, 32'd0);
    fetch(8'h48, 1'b1); tick();
    chk("refill_full", {31'd0, out_full}, 32'd1);
    chk("refill_idx", {29'd0, out_fetch_idx}, 32'd1);
    resolve(3'd1, 1'b1); tick();
    commit_exp(8'h41, 1'b1, 1'b0); fetch(8'h49, 1'b1); tick();
    chk("full_gate_idx", {29'd0, out_fetch_idx}, 32'd1);
    chk("full_gate_full", {31'd0, out_full}, 32'd0);
    resolve(3'd2, 1'b1); tick();
    commit_exp(8'h42, 1'b1, 1'b0); fetch(8'h4A, 1'b1); tick();
    chk("enq_retire_idx", {29'd0, out_fetch_idx}, 32'd2);
    chk("enq_retire_full", {31'd0, out_full}, 32'd0);

    // Stall with every request active, then reset mid-queue.
    resolve(3'd3, 1'b1); tick();
    rdy = 1'b0;
    repeat (2) begin
      fetch(8'h77, 1'b1); resolve(3'd4, 1'b1); in_commit = 1'b1; tick();
      chk("stall_idx", {29'd0, out_fetch_idx}, 32'd2);
      chk("stall_full", {31'd0, out_full}, 32'd0);
    end
    rdy = 1'b1;
    commit_exp(8'h43, 1'b1, 1'b0); tick();
    resolve(3'd4, 1'b0); tick();
    rst = 1'b1; rdy = 1'b0; in_commit = 1'b1; fetch(8'h66, 1'b1); tick();
    rst = 1'b0; rdy = 1'b1;
    chk("rst2_tag", {24'd0, out_bp_tag}, 32'd0);
    chk("rst2_taken", {31'd0, out_bp_taken}, 32'd0);
    chk("rst2_idx", {29'd0, out_fetch_idx}, 32'd0);
    chk("rst2_full", {31'd0, out_full}, 32'd0);
    in_commit = 1'b1; tick();
    fetch(8'h5A, 1'b0); tick();
    chk("post_rst_idx", {29'd0, out_fetch_idx}, 32'd1);
    resolve(3'd0, 1'b1); tick();
    commit_exp(8'h5A, 1'b1, 1'b1); tick();
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
